// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, default bit period and the receiver state encoding.
package uart_pkg;

    localparam int unsigned DATA_BITS        = 8;
    localparam int unsigned CLKS_PER_BIT_DEF = 16;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to 1 (line idle).
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= 1'b1;
            r_q    <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, sticky valid/frame-error/overrun flags cleared by i_read.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_rx,
    input  logic       i_read,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    uart_state_t           r_state;
    uart_state_t           w_state_nxt;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_nxt;
    logic [BW-1:0]         r_bit;
    logic [BW-1:0]         w_bit_nxt;
    logic [DATA_BITS-1:0]  r_shift;
    logic [7:0]            r_data;
    logic                  r_valid;
    logic                  r_frame_err;
    logic                  r_overrun;
    logic                  r_busy;
    logic                  w_rx_s;
    logic                  w_cnt_full;
    logic                  w_shift_en;
    logic                  w_done;
    logic                  w_ferr;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (i_rx),
        .o_q   (w_rx_s)
    );

    assign w_cnt_full = (r_cnt == FULL_M1);

    // State register and bit-timing counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            if (w_shift_en) begin
                r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            end
        end
    end

    // Next-state, counter update and sample strobes
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_en  = 1'b0;
        w_done      = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                end
            end
            S_START: begin
                if (r_cnt == HALF_M1) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (w_cnt_full) begin
                    w_cnt_nxt  = '0;
                    w_shift_en = 1'b1;
                    w_bit_nxt  = r_bit + BW'(1);
                    if (r_bit == LAST_BIT) begin
                        w_state_nxt = S_STOP;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_STOP: begin
                if (w_cnt_full) begin
                    w_cnt_nxt = '0;
                    if (w_rx_s) begin
                        w_done      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = S_WAIT_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_WAIT_IDLE: begin
                // Hold here through a break so a long low line cannot retrigger a frame
                if (w_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output holding register and sticky flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_done) begin
                if (!r_valid || i_read) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                    if (i_read) begin
                        r_frame_err <= 1'b0;
                        r_overrun   <= 1'b0;
                    end
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (i_read) begin
                r_valid     <= 1'b0;
                r_frame_err <= 1'b0;
                r_overrun   <= 1'b0;
            end
            if (w_ferr) begin
                r_frame_err <= 1'b1;
            end
        end
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; all checks sampled 1 time unit after posedge.
module tb_uart_rx;

    localparam int BIT = 16;

    logic       clk;
    logic       reset;
    logic       i_rx;
    logic       i_read;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_overrun;
    logic       o_busy;

    int n_vec;
    int n_err;

    uart_rx #(.CLKS_PER_BIT(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_rx        (i_rx),
        .i_read      (i_read),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun),
        .o_busy      (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives start + 8 data bits; returns just after the stop bit level is applied.
    // The receiver samples the stop bit 11 cycles after this returns.
    task automatic drive_frame(input logic [7:0] b, input logic stop_v);
        i_rx = 1'b0;
        tick(BIT);
        for (int k = 0; k < 8; k++) begin
            i_rx = b[k];
            tick(BIT);
        end
        i_rx = stop_v;
    endtask

    task automatic good_frame(input logic [7:0] b);
        drive_frame(b, 1'b1);
        tick(11);
        tick(5);
    endtask

    task automatic pulse_read();
        i_read = 1'b1;
        tick(1);
        i_read = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        i_rx  = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(5);
    endtask

    initial begin
        logic [7:0] b;
        n_vec  = 0;
        n_err  = 0;
        reset  = 1'b0;
        i_rx   = 1'b1;
        i_read = 1'b0;
        tick(3);
        chk("rst_data",  32'(o_data), 32'h00);
        chk("rst_valid", 32'(o_valid), 32'h0);
        chk("rst_ferr",  32'(o_frame_err), 32'h0);
        chk("rst_ovr",   32'(o_overrun), 32'h0);
        chk("rst_busy",  32'(o_busy), 32'h0);
        reset = 1'b1;
        tick(5);

        // Frame 0x55, good stop: valid exactly one cycle after the stop sample
        drive_frame(8'h55, 1'b1);
        tick(10);
        chk("f55_valid_early", 32'(o_valid), 32'h0);
        chk("f55_busy_early",  32'(o_busy), 32'h1);
        tick(1);
        chk("f55_valid", 32'(o_valid), 32'h1);
        chk("f55_data",  32'(o_data), 32'h55);
        chk("f55_ferr",  32'(o_frame_err), 32'h0);
        chk("f55_busy",  32'(o_busy), 32'h0);
        tick(5);
        pulse_read();
        chk("f55_read_valid", 32'(o_valid), 32'h0);
        tick(20);

        // 5-cycle glitch: false start rejected at the half-bit sample
        i_rx = 1'b0;
        tick(5);
        i_rx = 1'b1;
        chk("glitch_busy_start", 32'(o_busy), 32'h1);
        tick(5);
        chk("glitch_busy_last", 32'(o_busy), 32'h1);
        tick(1);
        chk("glitch_busy_idle", 32'(o_busy), 32'h0);
        chk("glitch_valid",     32'(o_valid), 32'h0);
        tick(20);

        // 0xA3 with low stop bit, then break held low for 40 cycles
        drive_frame(8'hA3, 1'b0);
        tick(11);
        chk("ferr_set",   32'(o_frame_err), 32'h1);
        chk("ferr_valid", 32'(o_valid), 32'h0);
        chk("ferr_busy",  32'(o_busy), 32'h1);
        tick(29);
        chk("brk_busy",  32'(o_busy), 32'h1);
        chk("brk_ferr",  32'(o_frame_err), 32'h1);
        chk("brk_valid", 32'(o_valid), 32'h0);
        i_rx = 1'b1;
        tick(2);
        chk("brk_busy_sync", 32'(o_busy), 32'h1);
        tick(1);
        chk("brk_busy_idle", 32'(o_busy), 32'h0);
        tick(200);
        chk("brk_no_frame_valid", 32'(o_valid), 32'h0);
        chk("brk_no_frame_busy",  32'(o_busy), 32'h0);
        do_reset();

        // 0x12 then 0x34 unread: second byte dropped, overrun flagged
        good_frame(8'h12);
        chk("ovr_first_valid", 32'(o_valid), 32'h1);
        chk("ovr_first_data",  32'(o_data), 32'h12);
        drive_frame(8'h34, 1'b1);
        tick(11);
        chk("ovr_data",  32'(o_data), 32'h12);
        chk("ovr_flag",  32'(o_overrun), 32'h1);
        chk("ovr_valid", 32'(o_valid), 32'h1);
        tick(5);
        pulse_read();
        chk("ovr_rd_valid", 32'(o_valid), 32'h0);
        chk("ovr_rd_flag",  32'(o_overrun), 32'h0);
        chk("ovr_rd_data",  32'(o_data), 32'h12);
        tick(10);

        // i_read coincident with completion of 0x34 while 0x12 is held
        good_frame(8'h12);
        chk("sim_hold_data", 32'(o_data), 32'h12);
        drive_frame(8'h34, 1'b1);
        tick(10);
        i_read = 1'b1;
        tick(1);
        i_read = 1'b0;
        chk("sim_data",  32'(o_data), 32'h34);
        chk("sim_valid", 32'(o_valid), 32'h1);
        chk("sim_ovr",   32'(o_overrun), 32'h0);
        tick(10);

        // Reset during bit 4 of frame 0xC3 (0x34 still held, valid=1)
        b = 8'hC3;
        i_rx = 1'b0;
        tick(BIT);
        for (int k = 0; k < 4; k++) begin
            i_rx = b[k];
            tick(BIT);
        end
        i_rx = b[4];
        tick(8);
        reset = 1'b0;
        #1;
        chk("mid_rst_data",  32'(o_data), 32'h00);
        chk("mid_rst_valid", 32'(o_valid), 32'h0);
        chk("mid_rst_ferr",  32'(o_frame_err), 32'h0);
        chk("mid_rst_ovr",   32'(o_overrun), 32'h0);
        chk("mid_rst_busy",  32'(o_busy), 32'h0);
        i_rx = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(200);
        chk("mid_rst_no_partial", 32'(o_valid), 32'h0);

        // Clean frame 0xF0 after the aborted one
        drive_frame(8'hF0, 1'b1);
        tick(10);
        chk("fF0_valid_early", 32'(o_valid), 32'h0);
        tick(1);
        chk("fF0_valid", 32'(o_valid), 32'h1);
        chk("fF0_data",  32'(o_data), 32'hF0);
        chk("fF0_ferr",  32'(o_frame_err), 32'h0);
        tick(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, giving clk cycles per serial bit (legal values: 4 or greater).
REQ-002 The block SHALL have port clk  input  1  system clock; all logic rises on the posedge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port i_rx  input  1  asynchronous serial line; idles high.
REQ-005 The block SHALL have port i_read  input  1  one-cycle strobe that consumes the held byte and clears the flags.
REQ-006 The block SHALL have port o_data  output  8  last received byte.
REQ-007 The block SHALL have port o_valid  output  1  sticky flag, set while o_data holds an unread byte.
REQ-008 The block SHALL have port o_frame_err  output  1  sticky flag, set when a stop bit is sampled low.
REQ-009 The block SHALL have port o_overrun  output  1  sticky flag, set when a byte is dropped because o_valid was already set.
REQ-010 The block SHALL have port o_busy  output  1  high in every state except IDLE.

Function
REQ-011 The block SHALL pass i_rx through a 2-flop synchronizer; all further logic SHALL use only the synchronized value rx_s.
REQ-012 The block SHALL use a state machine with states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-013 In IDLE, rx_s=0 SHALL clear the bit counter and the sample counter and move to START.
REQ-014 In START, the block SHALL sample rx_s when the sample counter reaches CLKS_PER_BIT/2-1 (integer division).
REQ-015 At that START sample, rx_s=1 SHALL be treated as a false start and return the block to IDLE; rx_s=0 SHALL move it to DATA with the sample counter reset.
REQ-016 In DATA, the block SHALL sample rx_s each time the sample counter reaches CLKS_PER_BIT-1, shifting LSB first into an 8-bit shift register.
REQ-017 After the 8th DATA sample, the block SHALL move to STOP.
REQ-018 In STOP, the block SHALL sample rx_s at count CLKS_PER_BIT-1.
REQ-019 A STOP sample of 1 SHALL complete the byte and return the block to IDLE.
REQ-020 A STOP sample of 0 SHALL set o_frame_err, discard the byte and move to WAIT_IDLE.
REQ-021 WAIT_IDLE SHALL return to IDLE on the first cycle with rx_s=1, so that a break condition does not retrigger reception.
REQ-022 On byte completion with o_valid=0, the block SHALL load o_data and set o_valid on the next clk edge; the latency from the STOP sample to o_valid is 1 cycle.
REQ-023 On byte completion with o_valid=1 and i_read=0, the block SHALL keep o_data unchanged, drop the new byte and set o_overrun.
REQ-024 On byte completion in the same cycle as i_read=1, the block SHALL load o_data, keep o_valid=1 and leave o_overrun clear.
REQ-025 Apart from the simultaneous case in REQ-024, i_read=1 SHALL clear o_valid, o_frame_err and o_overrun on the next edge; i_read with o_valid=0 SHALL have no further effect.
REQ-026 The sample counter SHALL be $clog2(CLKS_PER_BIT) bits wide and SHALL wrap to 0 at CLKS_PER_BIT-1; the bit counter SHALL be 3 bits wide.
REQ-027 o_busy SHALL be a registered decode of the state.

Reset
REQ-028 When reset=0, the block SHALL immediately force: state IDLE, counters 0, shift register 0, synchronizer flops 1, o_data=0, o_valid=0, o_frame_err=0, o_overrun=0, o_busy=0.
REQ-029 A reset asserted mid-frame SHALL abort the frame, and no partial byte SHALL be delivered.
REQ-030 After reset is released, the block SHALL wait in IDLE for a falling edge on rx_s; a line that is already low at release SHALL be treated as a start edge.

Structure
REQ-031 The state encoding, DATA_BITS=8 and the default CLKS_PER_BIT SHALL be placed in shared package uart_pkg, which uart_tx also uses.
REQ-032 The synchronizer SHALL be implemented as the single sub-module sync_2ff; all other logic SHALL reside in uart_rx.

Verification (CLKS_PER_BIT=16)
REQ-033 Bench SHALL cover: frame 0x55 with a valid stop bit -> o_valid=1 and o_data=0x55 at 1 cycle after the STOP sample, o_frame_err=0.
REQ-034 Bench SHALL cover: a 5-cycle low glitch on i_rx -> the block returns to IDLE from START with o_valid=0 and o_busy low again.
REQ-035 Bench SHALL cover: frame 0xA3 with the stop bit low, then the line held low for 40 cycles -> o_frame_err=1, o_valid=0, the block stays in WAIT_IDLE until i_rx goes high, and no second frame is received.
REQ-036 Bench SHALL cover: 0x12 then 0x34 with no i_read -> o_data=0x12 and o_overrun=1; a following i_read clears o_valid and o_overrun.
REQ-037 Bench SHALL cover: i_read coinciding with completion of 0x34 while 0x12 is held -> o_data=0x34, o_valid=1, o_overrun=0.
REQ-038 Bench SHALL cover: reset=0 pulsed during bit 4 of a frame -> all outputs read 0 immediately, and the next clean frame 0xF0 is received correctly.
